audio_i2s_tx: RTL and testbench

Serial audio transmitter on the consumer end of the PSG sample interface. It paces the audio pipeline by issuing a one-cycle `next_sample` request per frame and latches the 16-bit signed left/right samples. It then serializes them as standard I2S (MSB first, one-bit delay after LRCK) toward an external DAC. It sits between the PSG output and the board audio pins.

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_i2s_tx_if.sv | 23 ++
 rtl/audio_bck_gen.sv | 51 +++++
 rtl/audio_i2s_tx.sv | 100 ++++++++++
 tb/tb_audio_i2s_tx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants and state type for the I2S audio transmitter slice.
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int LEFT_SLOTS  = 16;
  localparam int FRAME_W     = 2 * SAMPLE_W;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample-request handshake from the PSG plus the I2S pin bundle toward the DAC.
interface audio_i2s_tx_if;
  import audio_pkg::*;

  logic                       enable;
  logic signed [SAMPLE_W-1:0] left_audio;
  logic signed [SAMPLE_W-1:0] right_audio;
  logic                       next_sample;
  logic                       i2s_bck;
  logic                       i2s_lrck;
  logic                       i2s_data;

  modport master (
    output enable, left_audio, right_audio,
    input  next_sample, i2s_bck, i2s_lrck, i2s_data
  );

  modport slave (
    input  enable, left_audio, right_audio,
    output next_sample, i2s_bck, i2s_lrck, i2s_data
  );

endinterface

// File: rtl/audio_bck_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags the cycle before each BCK edge.
module audio_bck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bck_q, bck_d;
  logic             term;

  assign term = en && (div_q == DIV_TERM);

  always_comb begin
    div_d = div_q;
    bck_d = bck_q;
    if (!en) begin
      div_d = '0;
      bck_d = 1'b0;
    end else if (term) begin
      div_d = '0;
      bck_d = ~bck_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      bck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bck_q <= bck_d;
    end
  end

  // Strobes are true in the cycle whose closing edge toggles BCK.
  assign bck_o       = bck_q;
  assign rise_tick_o = term && !bck_q;
  assign fall_tick_o = term &&  bck_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: paces the PSG with next_sample and shifts out {left,right} MSB first,
// one BCK after each LRCK change.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input logic            clk,
  input logic            rst,
  audio_i2s_tx_if.slave  bus
);

  tx_state_e         state_q;
  logic              run;
  logic              bck;
  logic              fall_tick;
  logic              rise_tick_unused;

  logic [SLOT_W-1:0]  slot_q, slot_d, slot_nxt;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               rlsb_q, rlsb_d;
  logic               lrck_q, lrck_d;
  logic               data_q, data_d;
  logic               req_q, req_d;
  logic               ns_q, ns_d;

  // Dropping enable stops everything on the same edge, so run folds in the live input.
  assign run = (state_q == ST_RUN) && bus.enable;

  audio_bck_gen #(.CLK_DIV(CLK_DIV)) u_bck_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (run),
    .bck_o       (bck),
    .rise_tick_o (rise_tick_unused),
    .fall_tick_o (fall_tick)
  );

  assign slot_nxt = slot_q + 1'b1;

  always_comb begin
    slot_d  = slot_q;
    shift_d = shift_q;
    rlsb_d  = rlsb_q;
    lrck_d  = lrck_q;
    data_d  = data_q;
    req_d   = 1'b0;
    ns_d    = req_q;
    if (!run) begin
      slot_d  = '0;
      shift_d = '0;
      rlsb_d  = 1'b0;
      lrck_d  = 1'b0;
      data_d  = 1'b0;
      ns_d    = 1'b0;
    end else if (fall_tick) begin
      slot_d = slot_nxt;
      lrck_d = (slot_nxt >= SLOT_W'(LEFT_SLOTS));
      if (slot_q == '0) begin
        shift_d = {bus.left_audio, bus.right_audio};
        data_d  = bus.left_audio[SAMPLE_W-1];
        req_d   = 1'b1;
      end else begin
        shift_d = shift_q << 1;
        // Slot 0 replays the right LSB parked while entering slot 31.
        data_d  = (slot_nxt == '0) ? rlsb_q : shift_q[FRAME_W-2];
        if (slot_nxt == SLOT_W'(FRAME_SLOTS - 1))
          rlsb_d = shift_q[FRAME_W-3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      shift_q <= '0;
      rlsb_q  <= 1'b0;
      lrck_q  <= 1'b0;
      data_q  <= 1'b0;
      req_q   <= 1'b0;
      ns_q    <= 1'b0;
    end else begin
      state_q <= bus.enable ? ST_RUN : ST_IDLE;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      rlsb_q  <= rlsb_d;
      lrck_q  <= lrck_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ns_q    <= ns_d;
    end
  end

  assign bus.next_sample = ns_q;
  assign bus.i2s_bck     = bck;
  assign bus.i2s_lrck    = lrck_q;
  assign bus.i2s_data    = data_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: decodes the I2S stream on BCK rise and times next_sample/LRCK.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int D     = 2;
  localparam int FRAME = 64 * D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audio_i2s_tx_if bus();

  audio_i2s_tx #(.CLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int   cyc = 0;
  logic bits[$];
  int   ns_times[$];
  int   lr_falls[$];
  int   first_rise, first_fall, falls, run_len, maxw;
  logic pb = 1'b0, pl = 1'b0, pn = 1'b0;

  task automatic clr();
    bits.delete();
    ns_times.delete();
    lr_falls.delete();
    first_rise = -1;
    first_fall = -1;
    falls      = 0;
    run_len    = 0;
    maxw       = 0;
  endtask

  // Advance one clk edge and observe the pins 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.i2s_bck && !pb) begin
      if (first_rise < 0) first_rise = cyc;
      bits.push_back(bus.i2s_data);
    end
    if (!bus.i2s_bck && pb) begin
      if (first_fall < 0) first_fall = cyc;
      falls++;
    end
    if (pl && !bus.i2s_lrck) lr_falls.push_back(cyc);
    if (bus.next_sample && !pn) ns_times.push_back(cyc);
    run_len = bus.next_sample ? run_len + 1 : 0;
    if (run_len > maxw) maxw = run_len;
    pb = bus.i2s_bck;
    pl = bus.i2s_lrck;
    pn = bus.next_sample;
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, bus.next_sample, bus.i2s_bck, bus.i2s_lrck, bus.i2s_data};
  endfunction

  function automatic int nsat(input int i);
    return (ns_times.size() > i) ? ns_times[i] : -1000;
  endfunction

  function automatic int lrat(input int i);
    return (lr_falls.size() > i) ? lr_falls[i] : -1000;
  endfunction

  // Word of 16 bits starting at BCK-rise index base, MSB first; X if not yet captured.
  function automatic logic [31:0] word(input int base);
    logic [15:0] w;
    w = 'x;
    if (bits.size() >= base + 16)
      for (int i = 0; i < 16; i++) w = {w[14:0], bits[base+i]};
    return 32'(w);
  endfunction

  int e0;
  int guard;
  bit changed;

  initial begin
    rst = 1'b1;
    bus.enable      = 1'b1;
    bus.left_audio  = 16'hA5F0;
    bus.right_audio = 16'h0F3C;
    clr();

    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq($sformatf("rst_outs_%0d", i), outs(), 32'd0);
    end

    rst = 1'b0;
    clr();
    e0 = cyc + 1;
    while (cyc < e0 + 10 * FRAME - 1) step();

    chk_eq("first_rise",    32'(first_rise - e0), 32'(D));
    chk_eq("ns_first",      32'(nsat(0) - e0), 32'(2 * D + 1));
    chk_eq("ns_after_fall", 32'(nsat(0) - first_fall), 32'd1);
    chk_eq("ns_count",      32'(ns_times.size()), 32'd10);
    chk_eq("ns_width",      32'(maxw), 32'd1);
    chk_eq("ns_period",     32'(nsat(1) - nsat(0)), 32'(FRAME));
    chk_eq("lrck_first",    32'(lrat(0) - e0), 32'(FRAME));
    chk_eq("lrck_period",   32'(lrat(1) - lrat(0)), 32'(FRAME));
    chk_eq("dec_L0",        word(1),  32'h0000A5F0);
    chk_eq("dec_R0",        word(17), 32'h00000F3C);
    chk_eq("slot0_rlsb",    32'(bits.size() > 32 ? bits[32] : 1'bx), 32'd0);
    chk_eq("dec_L1",        word(33), 32'h0000A5F0);
    chk_eq("dec_R1",        word(49), 32'h00000F3C);

    guard = 0;
    while (falls % 32 != 20 && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    chk_eq("wait_slot20", 32'(falls % 32), 32'd20);
    chk_eq("lrck_slot20", 32'(bus.i2s_lrck), 32'd1);
    bus.enable = 1'b0;
    step();
    chk_eq("drop_outs", outs(), 32'd0);
    repeat (10) step();
    chk_eq("idle_outs", outs(), 32'd0);

    bus.left_audio  = 16'h1234;
    bus.right_audio = 16'h7FFF;
    bus.enable      = 1'b1;
    clr();
    changed = 1'b0;
    e0 = cyc + 1;
    while (cyc < e0 + 3 * FRAME) begin
      step();
      if (!changed && ns_times.size() > 0 && cyc == nsat(0) + 2) begin
        bus.left_audio = 16'h8001;
        changed = 1'b1;
      end
    end
    chk_eq("reen_ns_first", 32'(nsat(0) - e0), 32'(2 * D + 1));
    chk_eq("chg_L0", word(1),  32'h00001234);
    chk_eq("chg_R0", word(17), 32'h00007FFF);
    chk_eq("chg_L1", word(33), 32'h00008001);
    chk_eq("chg_R1", word(49), 32'h00007FFF);

    guard = 0;
    while (falls % 32 != 9 && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    chk_eq("wait_slot9", 32'(falls % 32), 32'd9);
    rst = 1'b1;
    step();
    chk_eq("midrst_outs", outs(), 32'd0);
    rst = 1'b0;
    bus.left_audio  = 16'h5A3C;
    bus.right_audio = 16'hC3A5;
    clr();
    e0 = cyc + 1;
    while (cyc < e0 + FRAME + 8) step();
    chk_eq("rst_first_rise", 32'(first_rise - e0), 32'(D));
    chk_eq("rst_ns_first",   32'(nsat(0) - e0), 32'(2 * D + 1));
    chk_eq("rst_L0", word(1),  32'h00005A3C);
    chk_eq("rst_R0", word(17), 32'h0000C3A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
